// File: rtl/reg_file_param.sv
// Parametrised register file: byte-enabled write port, NUM_RD combinational read
// ports, optional zero register, optional write-to-read bypass and a busy scoreboard.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_be,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_ok;
    logic              rsv_ok;
    logic              set_new;
    logic              clr_old;
    logic [DATA_W-1:0] wr_merged;
    logic [ADDR_W-1:0] addr_k;

    // Write/reserve qualification, byte merge and the net scoreboard change.
    always_comb begin
        wr_ok     = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
        rsv_ok    = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
        wr_merged = regs[wr_addr];
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                wr_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
        set_new = rsv_ok && !busy[rsv_addr];
        clr_old = wr_en && busy[wr_addr] && !(rsv_ok && rsv_addr == wr_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_merged;
        end
    end

    // Set is scheduled after clear so a same-address reservation supersedes the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_en) begin
                busy[wr_addr] <= 1'b0;
            end
            if (rsv_ok) begin
                busy[rsv_addr] <= 1'b1;
            end
            case ({set_new, clr_old})
                2'b10:   busy_cnt <= busy_cnt + CNT_ONE;
                2'b01:   busy_cnt <= busy_cnt - CNT_ONE;
                default: busy_cnt <= busy_cnt;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        addr_k  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr_k = rd_addr[k*ADDR_W +: ADDR_W];
            rd_data[k*DATA_W +: DATA_W] = regs[addr_k];
            rd_busy[k] = busy[addr_k];
            if (BYPASS != 0 && rst_n && wr_en && wr_addr == addr_k) begin
                rd_data[k*DATA_W +: DATA_W] = wr_merged;
                rd_busy[k] = rsv_ok && rsv_addr == addr_k;
            end
            if (ZERO_REG != 0 && addr_k == '0) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed, table-driven bench for reg_file_param with default parameters,
// plus hand-written sequences for reset behaviour.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [5:0]  busy_cnt;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [5:0]  ec;
    } vec_t;

    vec_t vecs [20];

    reg_file_param dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [1:0] eb, input logic [5:0] ec);
        check_output({tag, " rd_data0"}, rd_data[31:0], e0);
        check_output({tag, " rd_data1"}, rd_data[63:32], e1);
        check_output({tag, " rd_busy"}, {30'd0, rd_busy}, {30'd0, eb});
        check_output({tag, " busy_cnt"}, {26'd0, busy_cnt}, {26'd0, ec});
    endtask

    task automatic idle_inputs();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_be    = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic apply_stimulus(input int i);
        wr_en    = vecs[i].we;
        wr_addr  = vecs[i].wa;
        wr_data  = vecs[i].wd;
        wr_be    = vecs[i].be;
        rsv_en   = vecs[i].re;
        rsv_addr = vecs[i].ra;
        rd_addr  = {vecs[i].a1, vecs[i].a0};
        #3;
        check_all($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].eb, vecs[i].ec);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          we  wa     wd            be       re  ra     a0     a1     e0            e1            eb     ec
        vecs[0]  = '{0, 5'd0,  32'h0,        4'b0000, 0, 5'd0,  5'd20, 5'd31, 32'h0,        32'h0,        2'b00, 6'd0};
        vecs[1]  = '{1, 5'd20, 32'h000000F5, 4'b1111, 0, 5'd0,  5'd20, 5'd31, 32'h000000F5, 32'h0,        2'b00, 6'd0};
        vecs[2]  = '{0, 5'd0,  32'h0,        4'b0000, 0, 5'd0,  5'd0,  5'd20, 32'h0,        32'h000000F5, 2'b00, 6'd0};
        vecs[3]  = '{1, 5'd17, 32'hAABBCCDD, 4'b1111, 0, 5'd0,  5'd17, 5'd17, 32'hAABBCCDD, 32'hAABBCCDD, 2'b00, 6'd0};
        vecs[4]  = '{1, 5'd17, 32'h11223344, 4'b0101, 0, 5'd0,  5'd17, 5'd20, 32'hAA22CC44, 32'h000000F5, 2'b00, 6'd0};
        vecs[5]  = '{0, 5'd0,  32'h0,        4'b0000, 0, 5'd0,  5'd17, 5'd17, 32'hAA22CC44, 32'hAA22CC44, 2'b00, 6'd0};
        vecs[6]  = '{1, 5'd0,  32'hFFFFFFFF, 4'b1111, 1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0};
        vecs[7]  = '{0, 5'd0,  32'h0,        4'b0000, 0, 5'd0,  5'd0,  5'd5,  32'h0,        32'h0,        2'b00, 6'd0};
        vecs[8]  = '{0, 5'd0,  32'h0,        4'b0000, 1, 5'd5,  5'd5,  5'd17, 32'h0,        32'hAA22CC44, 2'b00, 6'd0};
        vecs[9]  = '{0, 5'd0,  32'h0,        4'b0000, 0, 5'd0,  5'd5,  5'd0,  32'h0,        32'h0,        2'b01, 6'd1};
        vecs[10] = '{1, 5'd5,  32'h00000055, 4'b1111, 1, 5'd5,  5'd5,  5'd0,  32'h00000055, 32'h0,        2'b01, 6'd1};
        vecs[11] = '{0, 5'd0,  32'h0,        4'b0000, 0, 5'd0,  5'd5,  5'd0,  32'h00000055, 32'h0,        2'b01, 6'd1};
        vecs[12] = '{1, 5'd5,  32'h00000066, 4'b0000, 0, 5'd0,  5'd5,  5'd5,  32'h00000055, 32'h00000055, 2'b00, 6'd1};
        vecs[13] = '{0, 5'd0,  32'h0,        4'b0000, 0, 5'd0,  5'd5,  5'd5,  32'h00000055, 32'h00000055, 2'b00, 6'd0};
        vecs[14] = '{0, 5'd0,  32'h0,        4'b0000, 1, 5'd3,  5'd3,  5'd0,  32'h0,        32'h0,        2'b00, 6'd0};
        vecs[15] = '{0, 5'd0,  32'h0,        4'b0000, 1, 5'd4,  5'd3,  5'd4,  32'h0,        32'h0,        2'b01, 6'd1};
        vecs[16] = '{1, 5'd9,  32'h00000003, 4'b1111, 1, 5'd6,  5'd4,  5'd9,  32'h0,        32'h00000003, 2'b01, 6'd2};
        vecs[17] = '{0, 5'd0,  32'h0,        4'b0000, 0, 5'd0,  5'd6,  5'd9,  32'h0,        32'h00000003, 2'b01, 6'd3};
        vecs[18] = '{1, 5'd4,  32'h000000A0, 4'b0001, 1, 5'd7,  5'd4,  5'd7,  32'h000000A0, 32'h0,        2'b00, 6'd3};
        vecs[19] = '{0, 5'd0,  32'h0,        4'b0000, 0, 5'd0,  5'd4,  5'd7,  32'h000000A0, 32'h0,        2'b10, 6'd3};

        idle_inputs();
        rd_addr = {5'd31, 5'd20};
        rst_n   = 1'b0;
        #8;
        check_all("reset", 32'h0, 32'h0, 2'b00, 6'd0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(i);
        end

        // Asynchronous reset mid-cycle with registers 3, 6, 7 busy and reg 9 = 3.
        idle_inputs();
        rd_addr = {5'd9, 5'd6};
        #1;
        check_all("pre_reset", 32'h0, 32'h00000003, 2'b01, 6'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 32'h0, 32'h0, 2'b00, 6'd0);

        // Write and reserve coinciding with reset must be discarded.
        wr_en    = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'h00000007;
        wr_be    = 4'b1111;
        rsv_en   = 1'b1;
        rsv_addr = 5'd6;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check_all("in_reset", 32'h0, 32'h0, 2'b00, 6'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset", 32'h0, 32'h0, 2'b00, 6'd0);

        // Normal operation resumes after release.
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h12345678;
        wr_be   = 4'b1111;
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check_all("resume", 32'h0, 32'h12345678, 2'b00, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
